// File: rtl/imm_gen_stage_if.sv
// Handshake bundle for the immediate-decode stage: upstream instruction/PC in, decoded entry out.
// The stage binds to the slave modport; the neighbouring pipeline logic binds to master.
interface imm_gen_stage_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_imm_type;
    logic [XLEN-1:0] out_target;
    logic [XLEN-1:0] out_pc;
    logic            out_illegal;

    modport slave (
        input  in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_imm, out_imm_type, out_target, out_pc, out_illegal
    );

    modport master (
        output in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_imm, out_imm_type, out_target, out_pc, out_illegal
    );
endinterface

// File: rtl/imm_gen_stage.sv
// ID-stage immediate decoder: sign-extended immediate, pc+imm and illegal-opcode flag,
// registered behind a valid/ready port with an optional 2-entry skid buffer.
module imm_gen_stage #(
    parameter int XLEN = 32,
    parameter bit SKID = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    imm_gen_stage_if.slave     bus,
    output logic [1:0]         o_dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid && ready are both high;
    // the producer holds valid and payload stable until that edge, and ready never
    // depends on the same-side valid.

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] IMM_NONE = 3'd0;
    localparam logic [2:0] IMM_I    = 3'd1;
    localparam logic [2:0] IMM_S    = 3'd2;
    localparam logic [2:0] IMM_B    = 3'd3;
    localparam logic [2:0] IMM_U    = 3'd4;
    localparam logic [2:0] IMM_J    = 3'd5;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      imm_type;
        logic [XLEN-1:0] target;
        logic [XLEN-1:0] pc;
        logic            illegal;
    } entry_t;

    logic [31:0]     w_inst;
    logic [6:0]      w_opcode;
    logic [31:0]     w_imm32;
    logic [2:0]      w_imm_type;
    logic            w_illegal;
    logic [XLEN-1:0] w_imm;
    entry_t          w_in_entry;

    state_t          r_state;
    state_t          w_state_nxt;
    entry_t          r_main;
    entry_t          r_skid;
    logic            r_in_ready;

    logic            w_in_ready;
    logic            w_accept;
    logic            w_drain;
    logic            w_load_main_in;
    logic            w_load_main_skid;
    logic            w_load_skid;

    assign w_inst   = bus.in_inst;
    assign w_opcode = w_inst[6:0];

    // Every format fits a 32-bit signed value, so decode at 32 bits and widen once.
    always_comb begin
        w_imm32    = '0;
        w_imm_type = IMM_NONE;
        w_illegal  = 1'b0;
        case (w_opcode)
            OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM: begin
                w_imm32    = {{20{w_inst[31]}}, w_inst[31:20]};
                w_imm_type = IMM_I;
            end
            OPC_STORE: begin
                w_imm32    = {{20{w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
                w_imm_type = IMM_S;
            end
            OPC_BRANCH: begin
                w_imm32    = {{19{w_inst[31]}}, w_inst[31], w_inst[7], w_inst[30:25],
                              w_inst[11:8], 1'b0};
                w_imm_type = IMM_B;
            end
            OPC_JAL: begin
                w_imm32    = {{11{w_inst[31]}}, w_inst[31], w_inst[19:12], w_inst[20],
                              w_inst[30:21], 1'b0};
                w_imm_type = IMM_J;
            end
            OPC_LUI, OPC_AUIPC: begin
                w_imm32    = {w_inst[31:12], 12'b0};
                w_imm_type = IMM_U;
            end
            OPC_OP: begin
                w_imm_type = IMM_NONE;
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
    end

    generate
        if (XLEN == 64) begin : g_xlen64
            assign w_imm = {{(XLEN-32){w_imm32[31]}}, w_imm32};
        end else begin : g_xlen32
            assign w_imm = w_imm32;
        end
    endgenerate

    always_comb begin
        w_in_entry          = '0;
        w_in_entry.imm      = w_imm;
        w_in_entry.imm_type = w_imm_type;
        w_in_entry.target   = bus.in_pc + w_imm;
        w_in_entry.pc       = bus.in_pc;
        w_in_entry.illegal  = w_illegal;
    end

    // With SKID the ready is a flop (!skid_full); without it, ready looks through to out_ready.
    assign w_in_ready = !reset && (SKID ? r_in_ready : ((r_state == ST_EMPTY) || bus.out_ready));
    assign w_accept   = bus.in_valid && w_in_ready && !flush;
    assign w_drain    = (r_state != ST_EMPTY) && bus.out_ready;

    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt    = ST_ONE;
                    w_load_main_in = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_accept && w_drain) begin
                    w_load_main_in = 1'b1;
                end else if (w_accept) begin
                    w_state_nxt = ST_TWO;
                    w_load_skid = 1'b1;
                end else if (w_drain) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (w_drain) begin
                    w_state_nxt      = ST_ONE;
                    w_load_main_skid = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
        if (flush) begin
            w_state_nxt      = ST_EMPTY;
            w_load_main_in   = 1'b0;
            w_load_main_skid = 1'b0;
            w_load_skid      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_EMPTY;
            r_main     <= '0;
            r_skid     <= '0;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != ST_TWO);
            if (w_load_main_in) begin
                r_main <= w_in_entry;
            end else if (w_load_main_skid) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= w_in_entry;
            end
        end
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.out_valid    = (r_state != ST_EMPTY);
    assign bus.out_imm      = r_main.imm;
    assign bus.out_imm_type = r_main.imm_type;
    assign bus.out_target   = r_main.target;
    assign bus.out_pc       = r_main.pc;
    assign bus.out_illegal  = r_main.illegal;
    assign o_dbg_state      = r_state;

    // Held output must not move under back-pressure; the single-register build never fills skid.
    a_out_stable: assert property (@(posedge clk)
        (bus.out_valid && !bus.out_ready && !flush && !reset) |=>
        (bus.out_valid && $stable(r_main)));
    a_no_skid_when_off: assert property (@(posedge clk) SKID || (r_state != ST_TWO));

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: a 32-bit skid-buffered instance and a 64-bit single-register
// instance, each scored against an arithmetic model of the immediate formats.
module tb_imm_gen_stage;

    localparam int W = 196;

    logic clk = 1'b0;
    logic reset;
    logic flush;
    logic acc;
    logic [1:0] dbg_a;
    logic [1:0] dbg_b;
    int n_checks = 0;
    int n_fail = 0;
    logic [W-1:0] exp_q_a[$];
    logic [W-1:0] exp_q_b[$];

    always #5 clk = ~clk;

    imm_gen_stage_if #(.XLEN(32)) ia();
    imm_gen_stage_if #(.XLEN(64)) ib();

    imm_gen_stage #(.XLEN(32), .SKID(1'b1)) dut_a (
        .clk(clk), .reset(reset), .flush(flush), .bus(ia), .o_dbg_state(dbg_a));
    imm_gen_stage #(.XLEN(64), .SKID(1'b0)) dut_b (
        .clk(clk), .reset(reset), .flush(flush), .bus(ib), .o_dbg_state(dbg_b));

    // Immediate as a signed integer built from weighted instruction fields.
    function automatic logic [W-1:0] model(input logic [31:0] inst, input logic [63:0] pc,
                                           input int xlen);
        longint v;
        logic [2:0] t;
        logic ill;
        logic [63:0] mask;
        v = 0; t = 3'd0; ill = 1'b0;
        case (inst[6:0])
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
                v = longint'(inst[31:20]);
                if (v >= 2048) v = v - 4096;
                t = 3'd1;
            end
            7'b0100011: begin
                v = longint'({inst[31:25], inst[11:7]});
                if (v >= 2048) v = v - 4096;
                t = 3'd2;
            end
            7'b1100011: begin
                v = longint'(inst[7]) * 2048 + longint'(inst[30:25]) * 32
                  + longint'(inst[11:8]) * 2 - longint'(inst[31]) * 4096;
                t = 3'd3;
            end
            7'b1101111: begin
                v = longint'(inst[19:12]) * 4096 + longint'(inst[20]) * 2048
                  + longint'(inst[30:21]) * 2 - longint'(inst[31]) * 1048576;
                t = 3'd5;
            end
            7'b0110111, 7'b0010111: begin
                v = longint'(inst[30:12]) * 4096 - longint'(inst[31]) * (longint'(1) <<< 31);
                t = 3'd4;
            end
            7'b0110011: t = 3'd0;
            default: ill = 1'b1;
        endcase
        mask = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        return {ill, t, 64'(v) & mask, (pc + 64'(v)) & mask, pc & mask};
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [6:0] ops[10] = '{7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0100011,
                                7'b1100011, 7'b1101111, 7'b0110111, 7'b0010111, 7'b0110011};
        logic [31:0] r;
        logic [6:0] op;
        int idx;
        r = $urandom();
        idx = $urandom_range(0, 10);
        op = (idx == 10) ? r[6:0] : ops[idx];
        return {r[31:7], op};
    endfunction

    task automatic cyc_a(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                         input logic rdy, input logic fl, input logic rs, output logic accepted);
        logic [W-1:0] got;
        logic exp_rdy;
        @(posedge clk); #1;
        reset = rs; flush = fl;
        ia.in_valid = v; ia.in_inst = inst; ia.in_pc = pc; ia.out_ready = rdy;
        @(negedge clk);
        exp_rdy = !rs && (exp_q_a.size() < 2);
        n_checks++;
        if (ia.in_ready !== exp_rdy) begin
            n_fail++; $display("FAIL a_in_ready got=%0b exp=%0b t=%0t", ia.in_ready, exp_rdy, $time);
        end
        n_checks++;
        if (ia.out_valid !== (exp_q_a.size() != 0)) begin
            n_fail++; $display("FAIL a_out_valid got=%0b exp=%0b t=%0t", ia.out_valid, exp_q_a.size() != 0, $time);
        end
        if (exp_q_a.size() != 0) begin
            got = {ia.out_illegal, ia.out_imm_type, 32'h0, ia.out_imm, 32'h0, ia.out_target,
                   32'h0, ia.out_pc};
            n_checks++;
            if (got !== exp_q_a[0]) begin
                n_fail++; $display("FAIL a_entry got=%h exp=%h t=%0t", got, exp_q_a[0], $time);
            end
        end
        accepted = v && exp_rdy && !fl;
        if (rs || fl) begin
            exp_q_a.delete(); exp_q_b.delete();
        end else begin
            if (exp_q_a.size() != 0 && rdy) void'(exp_q_a.pop_front());
            if (accepted) exp_q_a.push_back(model(inst, {32'h0, pc}, 32));
        end
    endtask

    task automatic cyc_b(input logic v, input logic [31:0] inst, input logic [63:0] pc,
                         input logic rdy, output logic accepted);
        logic [W-1:0] got;
        logic exp_rdy;
        @(posedge clk); #1;
        reset = 1'b0; flush = 1'b0;
        ib.in_valid = v; ib.in_inst = inst; ib.in_pc = pc; ib.out_ready = rdy;
        @(negedge clk);
        exp_rdy = (exp_q_b.size() == 0) || rdy;
        n_checks++;
        if (ib.in_ready !== exp_rdy) begin
            n_fail++; $display("FAIL b_in_ready got=%0b exp=%0b t=%0t", ib.in_ready, exp_rdy, $time);
        end
        n_checks++;
        if (ib.out_valid !== (exp_q_b.size() != 0)) begin
            n_fail++; $display("FAIL b_out_valid got=%0b exp=%0b t=%0t", ib.out_valid, exp_q_b.size() != 0, $time);
        end
        if (exp_q_b.size() != 0) begin
            got = {ib.out_illegal, ib.out_imm_type, ib.out_imm, ib.out_target, ib.out_pc};
            n_checks++;
            if (got !== exp_q_b[0]) begin
                n_fail++; $display("FAIL b_entry got=%h exp=%h t=%0t", got, exp_q_b[0], $time);
            end
        end
        accepted = v && exp_rdy;
        if (exp_q_b.size() != 0 && rdy) void'(exp_q_b.pop_front());
        if (accepted) exp_q_b.push_back(model(inst, pc, 64));
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0;
        ia.in_valid = 1'b1; ia.in_inst = 32'h0000_0013; ia.in_pc = 32'h0; ia.out_ready = 1'b0;
        ib.in_valid = 1'b1; ib.in_inst = 32'h0000_0013; ib.in_pc = 64'h0; ib.out_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            n_checks++;
            if ({ia.in_ready, ib.in_ready} !== 2'b00) begin
                n_fail++; $display("FAIL reset_in_ready got=%b exp=00", {ia.in_ready, ib.in_ready});
            end
        end
        @(posedge clk); #1;
        reset = 1'b0; ia.in_valid = 1'b0; ib.in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({ia.out_valid, ia.out_illegal, ia.out_imm_type, ia.out_imm, ia.out_target, ia.out_pc} !== '0) begin
            n_fail++; $display("FAIL reset_a_outputs got=%h exp=0", {ia.out_valid, ia.out_illegal, ia.out_imm_type, ia.out_imm, ia.out_target, ia.out_pc});
        end
        n_checks++;
        if ({ib.out_valid, ib.out_illegal, ib.out_imm_type, ib.out_imm, ib.out_target, ib.out_pc} !== '0) begin
            n_fail++; $display("FAIL reset_b_outputs got=%h exp=0", {ib.out_valid, ib.out_illegal, ib.out_imm_type, ib.out_imm, ib.out_target, ib.out_pc});
        end
        n_checks++;
        if ({ia.in_ready, ib.in_ready, dbg_a, dbg_b} !== 6'b110000) begin
            n_fail++; $display("FAIL reset_ready_state got=%b exp=110000", {ia.in_ready, ib.in_ready, dbg_a, dbg_b});
        end
    endtask

    task automatic test_directed_32();
        cyc_a(1'b1, 32'hFE00_0EE3, 32'h100, 1'b1, 1'b0, 1'b0, acc);
        cyc_a(1'b1, 32'h0080_006F, 32'h200, 1'b1, 1'b0, 1'b0, acc);
        n_checks++;
        if ({ia.out_imm, ia.out_imm_type, ia.out_target} !== {32'hFFFF_FFFC, 3'd3, 32'h0000_00FC}) begin
            n_fail++; $display("FAIL beq got imm=%h type=%0d tgt=%h exp imm=fffffffc type=3 tgt=000000fc", ia.out_imm, ia.out_imm_type, ia.out_target);
        end
        cyc_a(1'b1, 32'h0000_000B, 32'h300, 1'b1, 1'b0, 1'b0, acc);
        n_checks++;
        if ({ia.out_imm, ia.out_imm_type, ia.out_target} !== {32'h8, 3'd5, 32'h208}) begin
            n_fail++; $display("FAIL jal got imm=%h type=%0d tgt=%h exp imm=8 type=5 tgt=208", ia.out_imm, ia.out_imm_type, ia.out_target);
        end
        cyc_a(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, acc);
        n_checks++;
        if ({ia.out_illegal, ia.out_imm, ia.out_imm_type} !== {1'b1, 32'h0, 3'd0}) begin
            n_fail++; $display("FAIL illegal got ill=%0b imm=%h type=%0d exp ill=1 imm=0 type=0", ia.out_illegal, ia.out_imm, ia.out_imm_type);
        end
        cyc_a(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, acc);
    endtask

    task automatic test_skid_backpressure();
        logic [2:0] accs;
        cyc_a(1'b1, 32'h0040_0093, 32'h1000, 1'b0, 1'b0, 1'b0, accs[0]);
        cyc_a(1'b1, 32'h0080_0113, 32'h1004, 1'b0, 1'b0, 1'b0, accs[1]);
        cyc_a(1'b1, 32'h00C0_0193, 32'h1008, 1'b0, 1'b0, 1'b0, accs[2]);
        n_checks++;
        if ({accs, ia.out_pc} !== {3'b011, 32'h1000}) begin
            n_fail++; $display("FAIL skid_fill got acc=%b pc=%h exp acc=011 pc=00001000", accs, ia.out_pc);
        end
        cyc_a(1'b1, 32'h00C0_0193, 32'h1008, 1'b1, 1'b0, 1'b0, accs[0]);
        cyc_a(1'b1, 32'h00C0_0193, 32'h1008, 1'b1, 1'b0, 1'b0, accs[1]);
        n_checks++;
        if ({accs[1:0], ia.out_valid, ia.out_pc} !== {2'b10, 1'b1, 32'h1004}) begin
            n_fail++; $display("FAIL skid_drain got acc=%b v=%0b pc=%h exp acc=10 v=1 pc=00001004", accs[1:0], ia.out_valid, ia.out_pc);
        end
        cyc_a(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, acc);
        n_checks++;
        if ({ia.out_valid, ia.out_pc} !== {1'b1, 32'h1008}) begin
            n_fail++; $display("FAIL skid_third got v=%0b pc=%h exp v=1 pc=00001008", ia.out_valid, ia.out_pc);
        end
        cyc_a(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, acc);
    endtask

    task automatic test_flush();
        cyc_a(1'b1, 32'h0010_0093, 32'h40, 1'b0, 1'b0, 1'b0, acc);
        cyc_a(1'b1, 32'h0020_0093, 32'h44, 1'b0, 1'b0, 1'b0, acc);
        cyc_a(1'b1, 32'h0030_0093, 32'h48, 1'b0, 1'b1, 1'b0, acc);
        cyc_a(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, acc);
        n_checks++;
        if ({ia.out_valid, ia.in_ready, dbg_a} !== 4'b0100) begin
            n_fail++; $display("FAIL flush_two got v/rdy/st=%b exp=0100", {ia.out_valid, ia.in_ready, dbg_a});
        end
        cyc_a(1'b1, 32'h0040_0093, 32'h50, 1'b0, 1'b0, 1'b0, acc);
        cyc_a(1'b1, 32'h0050_0093, 32'h54, 1'b0, 1'b1, 1'b0, acc);
        cyc_a(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, acc);
        cyc_a(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, acc);
        n_checks++;
        if ({ia.out_valid, ia.in_ready} !== 2'b01) begin
            n_fail++; $display("FAIL flush_drop got v/rdy=%b exp=01", {ia.out_valid, ia.in_ready});
        end
    endtask

    task automatic test_reset_mid_traffic();
        cyc_a(1'b1, 32'h1234_5037, 32'h80, 1'b0, 1'b0, 1'b0, acc);
        cyc_a(1'b1, 32'hFFF0_0013, 32'h84, 1'b0, 1'b0, 1'b0, acc);
        cyc_a(1'b1, 32'h0000_0063, 32'h88, 1'b1, 1'b0, 1'b1, acc);
        n_checks++;
        if (ia.in_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_ready got=%0b exp=0", ia.in_ready);
        end
        cyc_a(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, acc);
        n_checks++;
        if ({ia.in_ready, ia.out_valid, ia.out_illegal, ia.out_imm_type, ia.out_imm, ia.out_target, ia.out_pc} !== {1'b1, 101'h0}) begin
            n_fail++; $display("FAIL reset_mid_outputs got=%h exp=1 then zeros", {ia.in_ready, ia.out_valid, ia.out_illegal, ia.out_imm_type, ia.out_imm, ia.out_target, ia.out_pc});
        end
    endtask

    task automatic test_random_a();
        logic pend = 1'b0;
        logic [31:0] inst = '0;
        logic [31:0] pc = '0;
        logic fl;
        for (int i = 0; i < 400; i++) begin
            if (!pend && $urandom_range(0, 3) != 0) begin
                pend = 1'b1; inst = rand_inst(); pc = $urandom();
            end
            fl = ($urandom_range(0, 39) == 0);
            cyc_a(pend, inst, pc, $urandom_range(0, 2) != 0, fl, 1'b0, acc);
            if (acc || fl) pend = 1'b0;
        end
        for (int i = 0; i < 4; i++) cyc_a(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, acc);
        n_checks++;
        if (exp_q_a.size() != 0) begin
            n_fail++; $display("FAIL a_drain_left got=%0d exp=0", exp_q_a.size());
        end
    endtask

    task automatic test_xlen64();
        cyc_b(1'b1, 32'h8000_02B7, 64'h1000, 1'b1, acc);
        cyc_b(1'b1, 32'h1234_52B7, 64'h2000, 1'b1, acc);
        n_checks++;
        if ({ib.out_imm, ib.out_imm_type} !== {64'hFFFF_FFFF_8000_0000, 3'd4}) begin
            n_fail++; $display("FAIL lui_neg got imm=%h type=%0d exp imm=ffffffff80000000 type=4", ib.out_imm, ib.out_imm_type);
        end
        cyc_b(1'b0, 32'h0, 64'h0, 1'b1, acc);
        n_checks++;
        if ({ib.out_imm, ib.out_imm_type} !== {64'h0000_0000_1234_5000, 3'd4}) begin
            n_fail++; $display("FAIL lui_pos got imm=%h type=%0d exp imm=0000000012345000 type=4", ib.out_imm, ib.out_imm_type);
        end
        cyc_b(1'b0, 32'h0, 64'h0, 1'b1, acc);
    endtask

    task automatic test_random_b();
        logic pend = 1'b0;
        logic [31:0] inst = '0;
        logic [63:0] pc = '0;
        for (int i = 0; i < 400; i++) begin
            if (!pend && $urandom_range(0, 3) != 0) begin
                pend = 1'b1; inst = rand_inst(); pc = {$urandom(), $urandom()};
            end
            cyc_b(pend, inst, pc, $urandom_range(0, 2) != 0, acc);
            if (acc) pend = 1'b0;
        end
        for (int i = 0; i < 3; i++) cyc_b(1'b0, 32'h0, 64'h0, 1'b1, acc);
        n_checks++;
        if (exp_q_b.size() != 0) begin
            n_fail++; $display("FAIL b_drain_left got=%0d exp=0", exp_q_b.size());
        end
    endtask

    initial begin
        test_reset();
        test_directed_32();
        test_skid_backpressure();
        test_flush();
        test_reset_mid_traffic();
        test_random_a();
        test_xlen64();
        test_random_b();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
